// File: rtl/mdom_wvb_hdr_pkg.sv
// ============================================================================
// Module   : mdom_wvb_hdr_pkg
// Purpose  : wvb header field offsets and header readout arbiter state encoding
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdom_wvb_hdr_pkg;

  localparam int HDR_W          = 80;

  localparam int EVT_LTC_LSB    = 0;
  localparam int EVT_LTC_MSB    = 48;
  localparam int START_ADDR_LSB = 49;
  localparam int START_ADDR_MSB = 59;
  localparam int STOP_ADDR_LSB  = 60;
  localparam int STOP_ADDR_MSB  = 70;
  localparam int TRIG_SRC_LSB   = 71;
  localparam int TRIG_SRC_MSB   = 72;
  localparam int CNST_RUN_BIT   = 73;
  localparam int PRE_CONF_LSB   = 74;
  localparam int PRE_CONF_MSB   = 78;
  localparam int SYNC_RDY_BIT   = 79;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_XFER  = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mdom_rr_prio_enc.sv
// ============================================================================
// Module   : mdom_rr_prio_enc
// Purpose  : combinational round-robin priority encoder, search starts at last+1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdom_rr_prio_enc #(
  parameter int N     = 24,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int w_cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_cand  = 0;
    for (int i = N; i >= 1; i--) begin
      w_cand = int'(last) + i;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      if (req[w_cand[IDX_W-1:0]]) begin
        gnt_idx = w_cand[IDX_W-1:0];
        gnt_any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdom_wvb_hdr_rd_arb.sv
// ============================================================================
// Module   : mdom_wvb_hdr_rd_arb
// Purpose  : round-robin readout arbiter for per-channel wvb header FIFOs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdom_wvb_hdr_rd_arb
  import mdom_wvb_hdr_pkg::*;
#(
  parameter int N_CHAN = 24,
  parameter int CHAN_W = 5,
  parameter int HDR_W  = 80,
  parameter int ADDR_W = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CHAN-1:0]       hdr_rdy,
  input  logic [N_CHAN*HDR_W-1:0] hdr_bundle,
  output logic [N_CHAN-1:0]       hdr_rd_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [HDR_W-1:0]        out_hdr,
  output logic [CHAN_W-1:0]       out_chan,
  output logic [ADDR_W:0]         out_nsamp,
  input  logic                    rd_done,
  output logic                    busy
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [CHAN_W-1:0]   r_rr_last;
  logic [CHAN_W-1:0]   w_gnt_idx;
  logic                w_gnt_any;
  logic                w_grant;
  logic [HDR_W-1:0]    w_win_hdr;
  logic [ADDR_W-1:0]   w_start;
  logic [ADDR_W-1:0]   w_stop;
  logic [ADDR_W-1:0]   w_span;
  logic [ADDR_W:0]     w_nsamp;
  logic [N_CHAN-1:0]   r_rd_req;
  logic                r_out_valid;
  logic [HDR_W-1:0]    r_out_hdr;
  logic [CHAN_W-1:0]   r_out_chan;
  logic [ADDR_W:0]     r_out_nsamp;

  mdom_rr_prio_enc #(
    .N     (N_CHAN),
    .IDX_W (CHAN_W)
  ) u_prio_enc (
    .req     (hdr_rdy),
    .last    (r_rr_last),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  assign w_grant = (r_state == ST_IDLE) && en && w_gnt_any;

  always_comb begin
    w_win_hdr = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      if (w_gnt_idx == CHAN_W'(k)) begin
        w_win_hdr = hdr_bundle[k*HDR_W +: HDR_W];
      end
    end
  end

  // Modular subtraction in ADDR_W bits handles the circular-buffer wrap.
  assign w_start = w_win_hdr[START_ADDR_LSB +: ADDR_W];
  assign w_stop  = w_win_hdr[STOP_ADDR_LSB +: ADDR_W];
  assign w_span  = w_stop - w_start;
  assign w_nsamp = {1'b0, w_span} + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_grant)   w_state_nxt = ST_OFFER;
      ST_OFFER: if (out_ready) w_state_nxt = ST_XFER;
      ST_XFER:  if (rd_done)   w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_req    <= '0;
      r_out_valid <= 1'b0;
      r_out_hdr   <= '0;
      r_out_chan  <= '0;
      r_out_nsamp <= '0;
      r_rr_last   <= CHAN_W'(N_CHAN - 1);
    end else begin
      r_rd_req <= '0;
      if (w_grant) begin
        r_rd_req[w_gnt_idx] <= 1'b1;
        r_out_valid         <= 1'b1;
        r_out_hdr           <= w_win_hdr;
        r_out_chan          <= w_gnt_idx;
        r_out_nsamp         <= w_nsamp;
        r_rr_last           <= w_gnt_idx;
      end else if ((r_state == ST_OFFER) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign hdr_rd_req = r_rd_req;
  assign out_valid  = r_out_valid;
  assign out_hdr    = r_out_hdr;
  assign out_chan   = r_out_chan;
  assign out_nsamp  = r_out_nsamp;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mdom_wvb_hdr_rd_arb.sv
// ============================================================================
// Module   : tb_mdom_wvb_hdr_rd_arb
// Purpose  : self-checking bench for the wvb header readout arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdom_wvb_hdr_rd_arb;

  localparam int N_CHAN = 24;
  localparam int CHAN_W = 5;
  localparam int HDR_W  = 80;
  localparam int ADDR_W = 11;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic [N_CHAN-1:0]       hdr_rdy;
  logic [N_CHAN*HDR_W-1:0] hdr_bundle;
  logic [N_CHAN-1:0]       hdr_rd_req;
  logic                    out_valid;
  logic                    out_ready;
  logic [HDR_W-1:0]        out_hdr;
  logic [CHAN_W-1:0]       out_chan;
  logic [ADDR_W:0]         out_nsamp;
  logic                    rd_done;
  logic                    busy;

  mdom_wvb_hdr_rd_arb #(
    .N_CHAN (N_CHAN),
    .CHAN_W (CHAN_W),
    .HDR_W  (HDR_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .hdr_rdy    (hdr_rdy),
    .hdr_bundle (hdr_bundle),
    .hdr_rd_req (hdr_rd_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hdr    (out_hdr),
    .out_chan   (out_chan),
    .out_nsamp  (out_nsamp),
    .rd_done    (rd_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rdy;
    logic [10:0] st;
    logic [10:0] sp;
    int          ch;
    logic [11:0] ns;
  } vec_t;

  vec_t         tbl [8];
  logic [96:0]  exp_q [$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           pop_cnt [N_CHAN];
  int           mon_idx;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [79:0] mk_hdr(input int ch, input logic [10:0] st, input logic [10:0] sp);
    logic [8:0]  top;
    logic [48:0] ltc;
    top = 9'(ch * 37 + 1);
    ltc = 49'(ch) * 49'd1234567 + 49'h5A5;
    return {top, sp, st, ltc};
  endfunction

  task automatic set_hdrs(input logic [10:0] st, input logic [10:0] sp);
    for (int k = 0; k < N_CHAN; k++) hdr_bundle[k*HDR_W +: HDR_W] = mk_hdr(k, st, sp);
  endtask

  task automatic push_exp(input int ch, input logic [10:0] st, input logic [10:0] sp, input logic [11:0] ns);
    exp_q.push_back({5'(ch), ns, mk_hdr(ch, st, sp)});
  endtask

  // Offer/pop monitor, sampled mid-low-phase after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (hdr_rd_req != '0) begin
        mon_idx = 0;
        for (int k = 0; k < N_CHAN; k++) if (hdr_rd_req[k]) mon_idx = k;
        chk("pop_onehot", 128'($countones(hdr_rd_req)), 128'd1);
        chk("pop_chan", 128'(mon_idx), 128'(out_chan));
        pop_cnt[mon_idx]++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_offer", 128'(out_chan), 128'h1_0000);
        else chk("offer", {out_chan, out_nsamp, out_hdr}, exp_q.pop_front());
      end
    end
  end

  // One full transaction starting from IDLE at a negedge.
  task automatic run_txn(input logic [23:0] rdy, input int ch, input logic [10:0] st,
                         input logic [10:0] sp, input logic [11:0] ns, input bit hold);
    set_hdrs(st, sp);
    hdr_rdy   = rdy;
    out_ready = 1'b1;
    push_exp(ch, st, sp, ns);
    @(negedge clk);
    chk("grant_latency", 128'(out_valid), 128'd1);
    if (!hold) hdr_rdy = '0;
    @(negedge clk);
    chk("xfer_entered", 128'({busy, out_valid}), 128'b10);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    chk("idle_after_done", 128'(busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int p2;
    tbl[0] = '{24'h000001, 11'h7F0, 11'h00F,  0, 12'd32};
    tbl[1] = '{24'h000001, 11'h123, 11'h123,  0, 12'd1};
    tbl[2] = '{24'h000010, 11'h001, 11'h000,  4, 12'd2048};
    tbl[3] = '{24'h000003, 11'h100, 11'h1FF,  0, 12'd256};
    tbl[4] = '{24'h800001, 11'h000, 11'h7FF, 23, 12'd2048};
    tbl[5] = '{24'h800001, 11'h010, 11'h020,  0, 12'd17};
    tbl[6] = '{24'h000300, 11'h400, 11'h000,  8, 12'd1025};
    tbl[7] = '{24'h000300, 11'h7FF, 11'h000,  9, 12'd2};

    for (int k = 0; k < N_CHAN; k++) pop_cnt[k] = 0;
    rst_n = 1'b0; en = 1'b1; hdr_rdy = '0; out_ready = 1'b0; rd_done = 1'b0;
    set_hdrs(11'h0, 11'h0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, busy, hdr_rd_req, out_chan, out_nsamp, out_hdr}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 128'({out_valid, busy, hdr_rd_req}), 128'd0);

    // Table: round-robin order and sample-count arithmetic
    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].rdy, tbl[i].ch, tbl[i].st, tbl[i].sp, tbl[i].ns, 1'b0);

    // Offer held with out_ready low; rd_done during OFFER and on acceptance ignored
    p2 = pop_cnt[2];
    set_hdrs(11'h200, 11'h1FF);
    hdr_rdy = 24'h000004; out_ready = 1'b0;
    push_exp(2, 11'h200, 11'h1FF, 12'd2048);
    @(negedge clk);
    chk("hold_latency", 128'(out_valid), 128'd1);
    hdr_rdy = '0;
    set_hdrs(11'h000, 11'h000);
    for (int i = 0; i < 10; i++) begin
      rd_done = (i == 3);
      @(negedge clk);
      chk("offer_hold", {out_valid, out_chan, out_nsamp, out_hdr},
          {1'b1, 5'd2, 12'd2048, mk_hdr(2, 11'h200, 11'h1FF)});
    end
    chk("single_pop_in_hold", 128'(pop_cnt[2] - p2), 128'd1);
    out_ready = 1'b1; rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    chk("accept_cycle_done_ignored", 128'({busy, out_valid}), 128'b10);
    @(negedge clk);
    chk("xfer_waits", 128'(busy), 128'd1);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    chk("hold_done", 128'(busy), 128'd0);

    // en dropped in XFER: current transaction completes, no new grant
    hdr_rdy = 24'h000003;
    push_exp(0, 11'h000, 11'h000, 12'd1);
    @(negedge clk);
    chk("en_txn_latency", 128'(out_valid), 128'd1);
    @(negedge clk);
    en = 1'b0;
    chk("en_in_xfer", 128'({busy, out_valid}), 128'b10);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    chk("en_txn_done", 128'(busy), 128'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_grant_en0", 128'({busy, out_valid, hdr_rd_req}), 128'd0);
    end
    en = 1'b1;
    run_txn(24'h000003, 1, 11'h000, 11'h000, 12'd1, 1'b0);

    // Reset in OFFER aborts; channel 0 first afterwards
    set_hdrs(11'h003, 11'h005);
    hdr_rdy = 24'h000004; out_ready = 1'b0;
    push_exp(2, 11'h003, 11'h005, 12'd3);
    @(negedge clk);
    chk("pre_reset_offer", 128'(out_valid), 128'd1);
    hdr_rdy = 24'h800001;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, busy, hdr_rd_req, out_chan, out_nsamp, out_hdr}, 128'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_pop_in_reset", 128'({hdr_rd_req, out_valid}), 128'd0);
    end
    rst_n = 1'b1;
    run_txn(24'h800001, 0, 11'h003, 11'h005, 12'd3, 1'b0);

    // All channels ready and held: full rotation, one pop per channel per pass
    for (int k = 0; k < N_CHAN; k++) pop_cnt[k] = 0;
    for (int i = 0; i < N_CHAN; i++)
      run_txn(24'hFFFFFF, (i + 1) % N_CHAN, 11'h100, 11'h13F, 12'd64, 1'b1);
    bad = 0;
    for (int k = 0; k < N_CHAN; k++) if (pop_cnt[k] != 1) bad++;
    chk("pop_once_per_pass", 128'(bad), 128'd0);
    run_txn(24'hFFFFFF, 1, 11'h100, 11'h13F, 12'd64, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
